// File: rtl/ysyx_23060201_pkg.sv
// Shared types and constants for the ysyx_23060201 NPC front end.
// Holds the IFU state encoding, the AXI response code and the default reset PC.
package ysyx_23060201_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_ISSUE,
    S_WAIT,
    S_ERR
  } state_t;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
  localparam int          DEFAULT_CNT_W    = 64;

  // Instructions are word aligned; only the two low PC bits matter here.
  function automatic logic pc_aligned(input logic [1:0] pc_lsb);
    return pc_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_23060201_ifu.sv
// Non-pipelined instruction fetch unit: owns the PC, fetches one word over AXI-lite AR/R,
// hands it to the IDU and waits for the EXU's next PC before fetching again.
module ysyx_23060201_ifu
  import ysyx_23060201_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      araddr,
  output logic             arvalid,
  input  logic             arready,
  input  logic [31:0]      rdata,
  input  logic [1:0]       rresp,
  input  logic             rvalid,
  output logic             rready,
  output logic [31:0]      inst,
  output logic [31:0]      inst_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  input  logic [31:0]      dnpc,
  input  logic             dnpc_valid,
  output logic             fetch_err,
  output logic [CNT_W-1:0] fetch_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_inst;
  logic [31:0]      r_inst_pc;
  logic             r_fetch_err;
  logic [CNT_W-1:0] r_fetch_cnt;

  logic w_ar_fire;
  logic w_r_fire;
  logic w_inst_fire;

  // Handshake outputs are pure decodes of the registered state, so they never glitch.
  assign arvalid    = (r_state == S_ADDR);
  assign rready     = (r_state == S_DATA);
  assign inst_valid = (r_state == S_ISSUE);
  assign araddr     = r_pc;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign fetch_err  = r_fetch_err;
  assign fetch_cnt  = r_fetch_cnt;

  assign w_ar_fire   = arvalid & arready;
  assign w_r_fire    = rvalid & rready;
  assign w_inst_fire = inst_valid & inst_ready;

  // NOTE: every register below uses <= so all of them see the pre-edge values of each
  // other; a blocking = here would make the result depend on statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_inst      <= '0;
      r_inst_pc   <= '0;
      r_fetch_err <= 1'b0;
      r_fetch_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_ADDR;

        S_ADDR: begin
          if (w_ar_fire) r_state <= S_DATA;
        end

        S_DATA: begin
          if (w_r_fire) begin
            if (rresp == RESP_OKAY) begin
              r_inst    <= rdata;
              r_inst_pc <= r_pc;
              r_state   <= S_ISSUE;
            end else begin
              r_fetch_err <= 1'b1;
              r_state     <= S_ERR;
            end
          end
        end

        S_ISSUE: begin
          if (w_inst_fire) begin
            r_fetch_cnt <= r_fetch_cnt + CNT_ONE;
            r_state     <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (dnpc_valid) begin
            if (pc_aligned(dnpc[1:0])) begin
              r_pc    <= dnpc;
              r_state <= S_ADDR;
            end else begin
              r_fetch_err <= 1'b1;
              r_state     <= S_ERR;
            end
          end
        end

        S_ERR: r_state <= S_ERR;

        default: r_state <= S_ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060201_ifu.sv
// Self-checking bench for ysyx_23060201_ifu: randomized memory/IDU/EXU timing against a
// transaction-level model (expected PC, memory contents and handshake count).
module tb_ysyx_23060201_ifu;
  import ysyx_23060201_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int          CW     = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   araddr;
  logic          arvalid;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;
  logic [31:0]   inst;
  logic [31:0]   inst_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic [31:0]   dnpc;
  logic          dnpc_valid;
  logic          fetch_err;
  logic [CW-1:0] fetch_cnt;

  always #5 clk = ~clk;

  ysyx_23060201_ifu #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .araddr     (araddr),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rready     (rready),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .dnpc       (dnpc),
    .dnpc_valid (dnpc_valid),
    .fetch_err  (fetch_err),
    .fetch_cnt  (fetch_cnt)
  );

  int            errors = 0;
  int            checks = 0;
  logic [31:0]   exp_pc;
  logic [CW-1:0] exp_cnt;
  bit            dead;
  bit            in_wait   = 1'b0;
  bit            inject_ok = 1'b0;

  // dnpc_valid is only legal while the IFU waits for it, except for deliberate injections.
  always @(posedge clk)
    if (!rst && dnpc_valid)
      assert (in_wait || inject_ok) else $error("dnpc_valid pulsed outside the wait window");

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == RST_PC) ? 32'h0000_0413 : ((a * 32'h9E37_79B1) ^ 32'h0000_0013);
  endfunction

  task automatic idle_inputs();
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = RESP_OKAY;
    inst_ready = 1'b0; dnpc_valid = 1'b0; dnpc = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step(); step();
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_fetch_err", fetch_err, 1'b0);
    check("rst_fetch_cnt", fetch_cnt, '0);
    check("rst_inst", inst, '0);
    check("rst_inst_pc", inst_pc, '0);
    rst = 1'b0;
    exp_pc = RST_PC; exp_cnt = '0; dead = 1'b0;
    step();
    check("arvalid_after_rst", arvalid, 1'b1);
    check("araddr_reset_pc", araddr, RST_PC);
  endtask

  // After an error the IFU must stay silent whatever the environment does.
  task automatic check_dead(input int n);
    dead = 1'b1;
    for (int i = 0; i < n; i++) begin
      arready = 1'($urandom); rvalid = 1'($urandom); rdata = $urandom; inst_ready = 1'($urandom);
      step();
      check("dead_arvalid", arvalid, 1'b0);
      check("dead_inst_valid", inst_valid, 1'b0);
      check("dead_rready", rready, 1'b0);
      check("dead_fetch_err", fetch_err, 1'b1);
    end
    idle_inputs();
  endtask

  task automatic ar_phase(input int ar_delay, input bit bogus_r);
    int n = 0;
    while (!arvalid && n < 10) begin step(); n++; end
    check("ar_wait", arvalid, 1'b1);
    rvalid = bogus_r; rdata = 32'hDEAD_BEEF; rresp = 2'b10;
    for (int i = 0; i < ar_delay; i++) begin
      check("ar_hold_valid", arvalid, 1'b1);
      check("ar_hold_addr", araddr, exp_pc);
      step();
    end
    check("araddr", araddr, exp_pc);
    arready = 1'b1;
    step();
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = RESP_OKAY;
    check("ar_done_arvalid", arvalid, 1'b0);
    check("data_rready", rready, 1'b1);
  endtask

  task automatic r_phase(input int r_delay, input logic [1:0] resp, input bit inject);
    for (int i = 0; i < r_delay; i++) begin
      check("r_wait_rready", rready, 1'b1);
      check("r_wait_inst_valid", inst_valid, 1'b0);
      if (inject && i == 0) begin inject_ok = 1'b1; dnpc_valid = 1'b1; dnpc = 32'h1234_5670; end
      step();
      dnpc_valid = 1'b0; inject_ok = 1'b0;
    end
    rvalid = 1'b1; rdata = mem_word(exp_pc); rresp = resp;
    if (inject && r_delay == 0) begin inject_ok = 1'b1; dnpc_valid = 1'b1; dnpc = 32'h1234_5670; end
    step();
    rvalid = 1'b0; rdata = '0; rresp = RESP_OKAY; dnpc_valid = 1'b0; inject_ok = 1'b0;
    if (resp != RESP_OKAY) begin
      check("rresp_err", fetch_err, 1'b1);
      check_dead(6);
    end else begin
      check("inst_valid_latency", inst_valid, 1'b1);
      check("inst", inst, mem_word(exp_pc));
      check("inst_pc", inst_pc, exp_pc);
      check("no_err", fetch_err, 1'b0);
    end
  endtask

  task automatic issue_phase(input int rdy_delay);
    for (int i = 0; i < rdy_delay; i++) begin
      check("hold_inst_valid", inst_valid, 1'b1);
      check("hold_inst", inst, mem_word(exp_pc));
      check("hold_inst_pc", inst_pc, exp_pc);
      check("hold_cnt", fetch_cnt, exp_cnt);
      step();
    end
    check("pre_hs_cnt", fetch_cnt, exp_cnt);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    exp_cnt = exp_cnt + 1;
    check("issue_done", inst_valid, 1'b0);
    check("fetch_cnt", fetch_cnt, exp_cnt);
  endtask

  task automatic wait_phase(input int w_delay, input logic [31:0] next);
    in_wait = 1'b1;
    for (int i = 0; i < w_delay; i++) begin
      check("wait_arvalid", arvalid, 1'b0);
      check("wait_inst_valid", inst_valid, 1'b0);
      step();
    end
    dnpc = next; dnpc_valid = 1'b1;
    step();
    dnpc_valid = 1'b0; in_wait = 1'b0;
    if (next[1:0] != 2'b00) begin
      check("misaligned_err", fetch_err, 1'b1);
      check_dead(6);
    end else begin
      exp_pc = next;
      check("arvalid_after_dnpc", arvalid, 1'b1);
      check("araddr_dnpc", araddr, next);
    end
  endtask

  task automatic fetch_txn(input int ar_d, input int r_d, input logic [1:0] resp, input bit inject,
                           input bit bogus, input int rdy_d, input int w_d, input logic [31:0] next);
    ar_phase(ar_d, bogus);
    r_phase(r_d, resp, inject);
    if (dead) return;
    issue_phase(rdy_d);
    wait_phase(w_d, next);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] nxt;
    rst = 1'b1;
    idle_inputs();
    do_reset();

    // Zero-wait fetch of the reset instruction, then jump to 0x8000_0010.
    fetch_txn(0, 0, RESP_OKAY, 1'b0, 1'b0, 0, 0, 32'h8000_0010);
    // Slow memory, stray R and dnpc pulses, IDU stalls for five cycles.
    fetch_txn(3, 4, RESP_OKAY, 1'b1, 1'b1, 5, 0, 32'hFFFF_FFFC);
    fetch_txn(0, 1, RESP_OKAY, 1'b0, 1'b0, 1, 2, 32'h0000_0000);

    for (int t = 0; t < 40; t++) begin
      nxt = ($urandom_range(0, 1) == 0) ? exp_pc + 32'd4 : ($urandom() & 32'hFFFF_FFFC);
      fetch_txn($urandom_range(0, 3), $urandom_range(0, 4), RESP_OKAY, 1'($urandom), 1'($urandom),
                $urandom_range(0, 5), $urandom_range(0, 3), nxt);
    end

    // Error response is terminal until reset; fetching then restarts at the reset PC.
    fetch_txn(1, 1, 2'b10, 1'b0, 1'b0, 0, 0, 32'h0);
    do_reset();
    fetch_txn(0, 0, RESP_OKAY, 1'b0, 1'b0, 0, 0, 32'h8000_0002);
    do_reset();
    fetch_txn(1, 0, RESP_OKAY, 1'b0, 1'b0, 2, 1, 32'h8000_0100);

    // Reset while a read is outstanding; the stale response must not be captured.
    ar_phase(1, 1'b0);
    rvalid = 1'b1; rdata = 32'hBAD0_0BAD; rresp = RESP_OKAY;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_rready", rready, 1'b0);
    check("midrst_arvalid", arvalid, 1'b0);
    check("midrst_inst_valid", inst_valid, 1'b0);
    check("midrst_cnt", fetch_cnt, '0);
    check("midrst_inst", inst, '0);
    step();
    rvalid = 1'b0; rdata = '0;
    exp_pc = RST_PC; exp_cnt = '0;
    check("midrst_arvalid_again", arvalid, 1'b1);
    check("midrst_araddr", araddr, RST_PC);
    fetch_txn(0, 0, RESP_OKAY, 1'b0, 1'b0, 0, 0, 32'h8000_0004);
    fetch_txn(2, 2, RESP_OKAY, 1'b0, 1'b0, 1, 1, 32'h8000_0008);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
